hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Pipeline hazard controller for the 5-stage core; consumes the ID/EX, EX/MEM and MEM/WB
//  register fields and drives the stall/flush/forward controls back into those registers.
//  Resolves RAW hazards by forwarding, load-use and branch-compare hazards by stalling.
//  Tracks the multi-cycle mult/div unit and holds dependent decode ops until it finishes.
// PARAMETERS
//  MULDIV_LAT  32  cycles the mult/div unit is busy after start (>=2)
//  CNT_W       32  width of the stall-cycle performance counter
// PORTS
//  clk            in   1  core clock; all state updates on posedge
//  rst_n          in   1  synchronous, active-low reset
//  Rs_D, Rt_D     in   5  source regs of instruction in decode
//  Branch_D       in   1  decode instr is beq/bne (compare resolved in ID)
//  MulDiv_D       in   1  decode instr is mult/div/mfhi/mflo
//  Rs_E, Rt_E     in   5  source regs held in ID/EX
//  WriteReg_E     in   5  dest reg in EX
//  RegWrite_E     in   1  EX instr writes reg file
//  MemtoReg_E     in   1  EX instr is a load
//  MulDivStart_E  in   1  EX instr starts mult/div this cycle
//  WriteReg_M     in   5  dest reg in MEM;  RegWrite_M in 1;  MemtoReg_M in 1 (load in MEM)
//  WriteReg_W     in   5  dest reg in WB;   RegWrite_W in 1
//  StallF         out  1  hold PC
//  StallD         out  1  hold IF/ID
//  FlushE         out  1  clear ID/EX to bubble (all control fields 0)
//  ForwardAD/BD   out  1  select ALUOut_M for ID branch comparator operand A/B
//  ForwardAE/BE   out  2  EX operand select: 00 reg file, 01 Result_W, 10 ALUOut_M
//  MulDivBusy     out  1  mult/div unit busy
//  StallCount     out  CNT_W  cycles with StallD=1 since reset, saturating
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state<=IDLE, busy counter<=0, StallCount<=0.
//   While rst_n=0 outputs forced: StallF=StallD=0, FlushE=1, all Forward*=0, MulDivBusy=0.
//  Register $0 never matches: any comparison with reg 0 yields no forward and no stall.
//  Forwarding (combinational, zero latency):
//   ForwardAE=10 if RegWrite_M & WriteReg_M==Rs_E; else 01 if RegWrite_W & WriteReg_W==Rs_E;
//   else 00. MEM has priority over WB. ForwardBE identical using Rt_E.
//   ForwardAD=RegWrite_M & WriteReg_M==Rs_D; ForwardBD same with Rt_D.
//  Stall terms (combinational):
//   lwstall = MemtoReg_E & (Rt_E==Rs_D | Rt_E==Rt_D)
//   brstall = Branch_D & ((RegWrite_E & WriteReg_E in {Rs_D,Rt_D})
//             | (MemtoReg_M & WriteReg_M in {Rs_D,Rt_D}))
//   mdstall = MulDiv_D & (state==BUSY | MulDivStart_E)
//   stall = lwstall|brstall|mdstall; StallF=StallD=FlushE=stall.
//  Mult/div FSM, states IDLE, BUSY:
//   IDLE: MulDivStart_E=1 -> BUSY, cnt<=MULDIV_LAT-1.
//   BUSY: cnt!=0 -> cnt<=cnt-1; cnt==0 -> IDLE. MulDivStart_E is ignored in BUSY:
//   it cannot occur because mdstall holds such ops in decode.
//   MulDivBusy = (state==BUSY). The busy window is MULDIV_LAT cycles after the start cycle.
//   A dependent decode op proceeds in the first cycle after BUSY returns to IDLE.
//  StallCount: +1 on each posedge where StallD=1 and rst_n=1; holds at all-ones.
//  Reset mid-BUSY: FSM returns to IDLE on that edge; no residual stall afterwards.
//  Simultaneous hazards: stall terms OR together; forwarding still computed during stall.
// STRUCTURE
//  Shared package core_pkg: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; REG_ZERO=5'd0;
//  muldiv_state_t enum {IDLE, BUSY}.
//  One sub-module: muldiv_tracker (FSM + down-counter, outputs busy).
//  Forwarding/stall logic stays flat in hazard_unit.
// TESTING
//  1. RegWrite_M=1, WriteReg_M=8, RegWrite_W=1, WriteReg_W=8, Rs_E=8 -> ForwardAE=10 (MEM wins).
//  2. MemtoReg_E=1, Rt_E=9, Rs_D=9 -> StallF=StallD=FlushE=1 for exactly 1 cycle,
//     then 0 once the load moves to MEM, and ForwardAE=01 one cycle later.
//  3. Branch_D=1, Rs_D=10, RegWrite_E=1, WriteReg_E=10 -> stall 1 cycle.
//     Next cycle the writer is in MEM (not a load) -> ForwardAD=1, no stall.
//  4. MULDIV_LAT=4: MulDivStart_E pulse at cycle 0, MulDiv_D=1 held from cycle 0 ->
//     StallD=1 at cycles 0..4, 0 at cycle 5. MulDivBusy=1 at cycles 1..4.
//  5. WriteReg_M=0, RegWrite_M=1, Rs_E=0 -> ForwardAE=00. MemtoReg_E=1, Rt_E=0, Rs_D=0 -> no stall.
//  6. rst_n=0 for one edge during BUSY -> MulDivBusy=0, StallCount=0, FlushE=1 while low.
//     Also: StallCount with CNT_W=4 saturates at 15.

Source files
------------

// File: rtl/core_pkg.sv
// Shared hazard-control encodings and register-compare helper.
package core_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } muldiv_state_t;

    // Register $0 is hardwired, so it never creates a dependence.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != REG_ZERO) && (a == b);
    endfunction

endpackage

// File: rtl/muldiv_tracker.sv
// Tracks the multi-cycle mult/div unit: busy for MULDIV_LAT cycles after a start.
module muldiv_tracker
    import core_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy
);

    localparam int unsigned CW = $clog2(MULDIV_LAT);

    muldiv_state_t   state;
    logic [CW-1:0]   cnt;

    // State and down-counter; starts arriving while busy are held off upstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= BUSY;
                        cnt   <= CW'(MULDIV_LAT - 1);
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == BUSY);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding selects, stall/flush, mult/div tracking.
module hazard_unit
    import core_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 32,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs_D,
    input  logic [4:0]       Rt_D,
    input  logic             Branch_D,
    input  logic             MulDiv_D,
    input  logic [4:0]       Rs_E,
    input  logic [4:0]       Rt_E,
    input  logic [4:0]       WriteReg_E,
    input  logic             RegWrite_E,
    input  logic             MemtoReg_E,
    input  logic             MulDivStart_E,
    input  logic [4:0]       WriteReg_M,
    input  logic             RegWrite_M,
    input  logic             MemtoReg_M,
    input  logic [4:0]       WriteReg_W,
    input  logic             RegWrite_W,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MulDivBusy,
    output logic [CNT_W-1:0] StallCount
);

    logic md_busy;
    logic lwstall;
    logic brstall;
    logic mdstall;
    logic stall;

    muldiv_tracker #(
        .MULDIV_LAT (MULDIV_LAT)
    ) u_muldiv_tracker (
        .clk   (clk),
        .rst_n (rst_n),
        .start (MulDivStart_E),
        .busy  (md_busy)
    );

    // Stall terms and forwarding selects; everything is forced quiet while in reset.
    always_comb begin
        lwstall   = 1'b0;
        brstall   = 1'b0;
        mdstall   = 1'b0;
        stall     = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;

        lwstall = MemtoReg_E & (reg_match(Rt_E, Rs_D) | reg_match(Rt_E, Rt_D));
        brstall = Branch_D &
                  ((RegWrite_E & (reg_match(WriteReg_E, Rs_D) | reg_match(WriteReg_E, Rt_D))) |
                   (MemtoReg_M & (reg_match(WriteReg_M, Rs_D) | reg_match(WriteReg_M, Rt_D))));
        mdstall = MulDiv_D & (md_busy | MulDivStart_E);
        stall   = rst_n & (lwstall | brstall | mdstall);

        if (rst_n) begin
            if (RegWrite_M && reg_match(WriteReg_M, Rs_E)) begin
                ForwardAE = FWD_MEM;
            end else if (RegWrite_W && reg_match(WriteReg_W, Rs_E)) begin
                ForwardAE = FWD_WB;
            end
            if (RegWrite_M && reg_match(WriteReg_M, Rt_E)) begin
                ForwardBE = FWD_MEM;
            end else if (RegWrite_W && reg_match(WriteReg_W, Rt_E)) begin
                ForwardBE = FWD_WB;
            end
            ForwardAD = RegWrite_M & reg_match(WriteReg_M, Rs_D);
            ForwardBD = RegWrite_M & reg_match(WriteReg_M, Rt_D);
        end
    end

    assign StallF     = stall;
    assign StallD     = stall;
    assign FlushE     = stall | ~rst_n;
    assign MulDivBusy = md_busy & rst_n;

    // Saturating count of decode-stall cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            StallCount <= '0;
        end else if (stall && (StallCount != {CNT_W{1'b1}})) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with MULDIV_LAT=4 and CNT_W=4.
module tb_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
    logic       Branch_D, MulDiv_D, RegWrite_E, MemtoReg_E, MulDivStart_E;
    logic       RegWrite_M, MemtoReg_M, RegWrite_W;
    logic       StallF, StallD, FlushE, ForwardAD, ForwardBD, MulDivBusy;
    logic [1:0] ForwardAE, ForwardBE;
    logic [3:0] StallCount;

    int total = 0;
    int bad   = 0;

    hazard_unit #(
        .MULDIV_LAT (4),
        .CNT_W      (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Rs_D          (Rs_D),
        .Rt_D          (Rt_D),
        .Branch_D      (Branch_D),
        .MulDiv_D      (MulDiv_D),
        .Rs_E          (Rs_E),
        .Rt_E          (Rt_E),
        .WriteReg_E    (WriteReg_E),
        .RegWrite_E    (RegWrite_E),
        .MemtoReg_E    (MemtoReg_E),
        .MulDivStart_E (MulDivStart_E),
        .WriteReg_M    (WriteReg_M),
        .RegWrite_M    (RegWrite_M),
        .MemtoReg_M    (MemtoReg_M),
        .WriteReg_W    (WriteReg_W),
        .RegWrite_W    (RegWrite_W),
        .StallF        (StallF),
        .StallD        (StallD),
        .FlushE        (FlushE),
        .ForwardAD     (ForwardAD),
        .ForwardBD     (ForwardBD),
        .ForwardAE     (ForwardAE),
        .ForwardBE     (ForwardBE),
        .MulDivBusy    (MulDivBusy),
        .StallCount    (StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, ".StallF"}, 32'(StallF), 32'(exp));
        chk({tag, ".StallD"}, 32'(StallD), 32'(exp));
        chk({tag, ".FlushE"}, 32'(FlushE), 32'(exp));
    endtask

    task automatic clear_inputs();
        Rs_D = 5'd0; Rt_D = 5'd0; Branch_D = 1'b0; MulDiv_D = 1'b0;
        Rs_E = 5'd0; Rt_E = 5'd0; WriteReg_E = 5'd0; RegWrite_E = 1'b0;
        MemtoReg_E = 1'b0; MulDivStart_E = 1'b0;
        WriteReg_M = 5'd0; RegWrite_M = 1'b0; MemtoReg_M = 1'b0;
        WriteReg_W = 5'd0; RegWrite_W = 1'b0;
    endtask

    // Inputs settle after posedge+1; checks happen at the following negedge.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        // Reset with hazards present: outputs must stay forced.
        MemtoReg_E = 1'b1; Rt_E = 5'd9; Rs_D = 5'd9;
        RegWrite_M = 1'b1; WriteReg_M = 5'd8; Rs_E = 5'd8;
        sample();
        chk("rst.StallD", 32'(StallD), 32'd0);
        chk("rst.StallF", 32'(StallF), 32'd0);
        chk("rst.FlushE", 32'(FlushE), 32'd1);
        chk("rst.ForwardAE", 32'(ForwardAE), 32'd0);
        chk("rst.ForwardAD", 32'(ForwardAD), 32'd0);
        chk("rst.MulDivBusy", 32'(MulDivBusy), 32'd0);
        next_cycle();
        chk("rst.StallCount", 32'(StallCount), 32'd0);
        rst_n = 1'b1;
        clear_inputs();
        sample();
        chk_stall("idle", 1'b0);

        // MEM beats WB; then WB alone.
        next_cycle();
        RegWrite_M = 1'b1; WriteReg_M = 5'd8; RegWrite_W = 1'b1; WriteReg_W = 5'd8;
        Rs_E = 5'd8; Rt_E = 5'd8;
        sample();
        chk("fwd.mem.AE", 32'(ForwardAE), 32'd2);
        chk("fwd.mem.BE", 32'(ForwardBE), 32'd2);
        chk_stall("fwd.mem", 1'b0);
        next_cycle();
        RegWrite_M = 1'b0; Rt_E = 5'd3;
        sample();
        chk("fwd.wb.AE", 32'(ForwardAE), 32'd1);
        chk("fwd.wb.BE", 32'(ForwardBE), 32'd0);

        // Load-use: one stall, load moves to MEM, dependent reaches EX with WB forward.
        next_cycle();
        clear_inputs();
        MemtoReg_E = 1'b1; RegWrite_E = 1'b1; WriteReg_E = 5'd9; Rt_E = 5'd9; Rs_D = 5'd9;
        sample();
        chk_stall("lw.c0", 1'b1);
        next_cycle();
        clear_inputs();
        Rs_D = 5'd9; RegWrite_M = 1'b1; MemtoReg_M = 1'b1; WriteReg_M = 5'd9;
        sample();
        chk_stall("lw.c1", 1'b0);
        chk("lw.c1.AD", 32'(ForwardAD), 32'd1);
        chk("lw.c1.Count", 32'(StallCount), 32'd1);
        next_cycle();
        clear_inputs();
        Rs_E = 5'd9; RegWrite_W = 1'b1; WriteReg_W = 5'd9;
        sample();
        chk("lw.c2.AE", 32'(ForwardAE), 32'd1);
        chk_stall("lw.c2", 1'b0);

        // Branch compare dependences.
        next_cycle();
        clear_inputs();
        Branch_D = 1'b1; Rs_D = 5'd10; RegWrite_E = 1'b1; WriteReg_E = 5'd10;
        sample();
        chk_stall("br.ex", 1'b1);
        next_cycle();
        RegWrite_E = 1'b0; WriteReg_E = 5'd0; RegWrite_M = 1'b1; WriteReg_M = 5'd10;
        sample();
        chk_stall("br.mem", 1'b0);
        chk("br.mem.AD", 32'(ForwardAD), 32'd1);
        next_cycle();
        MemtoReg_M = 1'b1;
        sample();
        chk_stall("br.ldmem", 1'b1);
        next_cycle();
        Rs_D = 5'd3; Rt_D = 5'd10;
        sample();
        chk_stall("br.ldmem.rt", 1'b1);
        chk("br.ldmem.BD", 32'(ForwardBD), 32'd1);
        chk("br.ldmem.AD", 32'(ForwardAD), 32'd0);

        // Register $0 never matches.
        next_cycle();
        clear_inputs();
        RegWrite_M = 1'b1; RegWrite_W = 1'b1; MemtoReg_E = 1'b1;
        Branch_D = 1'b1; RegWrite_E = 1'b1; MemtoReg_M = 1'b1;
        sample();
        chk("r0.AE", 32'(ForwardAE), 32'd0);
        chk("r0.BE", 32'(ForwardBE), 32'd0);
        chk("r0.AD", 32'(ForwardAD), 32'd0);
        chk_stall("r0", 1'b0);
        chk("r0.Count", 32'(StallCount), 32'd4);

        // Mult/div: start at cycle 0, dependent op held through cycle 4.
        next_cycle();
        clear_inputs();
        MulDivStart_E = 1'b1; MulDiv_D = 1'b1;
        sample();
        chk("md.c0.StallD", 32'(StallD), 32'd1);
        chk("md.c0.Busy", 32'(MulDivBusy), 32'd0);
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            MulDivStart_E = 1'b0;
            sample();
            chk($sformatf("md.c%0d.StallD", c), 32'(StallD), (c <= 4) ? 32'd1 : 32'd0);
            chk($sformatf("md.c%0d.Busy", c), 32'(MulDivBusy), (c <= 4) ? 32'd1 : 32'd0);
        end
        chk("md.Count", 32'(StallCount), 32'd9);

        // Saturation of the 4-bit stall counter.
        next_cycle();
        clear_inputs();
        MemtoReg_E = 1'b1; Rt_E = 5'd9; Rs_D = 5'd9;
        for (int i = 0; i < 10; i++) begin
            sample();
            chk($sformatf("sat.%0d", i), 32'(StallCount), (9 + i > 15) ? 32'd15 : 32'(9 + i));
            next_cycle();
        end
        clear_inputs();
        sample();
        chk("sat.final", 32'(StallCount), 32'd15);

        // Reset in the middle of a busy window.
        next_cycle();
        MulDivStart_E = 1'b1;
        sample();
        next_cycle();
        MulDivStart_E = 1'b0;
        sample();
        chk("mdrst.busy_before", 32'(MulDivBusy), 32'd1);
        next_cycle();
        rst_n = 1'b0; MulDiv_D = 1'b1;
        sample();
        chk("mdrst.low.Busy", 32'(MulDivBusy), 32'd0);
        chk("mdrst.low.FlushE", 32'(FlushE), 32'd1);
        chk("mdrst.low.StallD", 32'(StallD), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            sample();
            chk($sformatf("mdrst.after%0d.Busy", c), 32'(MulDivBusy), 32'd0);
            chk_stall($sformatf("mdrst.after%0d", c), 1'b0);
            chk($sformatf("mdrst.after%0d.Count", c), 32'(StallCount), 32'd0);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
